gshare_pht: RTL and testbench
=============================

Name: gshare_pht

Overview:
- Parametrised pattern history table for the gshare branch predictor, replacing the fixed 256x2 single-port SRAM macro.
- Holds 2^IDX_W saturating counters of CTR_W bits. Provides an independent predict read port and an update port that performs the saturating read-modify-write internally.
- After reset or flush, a hardware init sweep sets every entry to weakly-not-taken.
- Sits between the fetch-stage gshare index hash (predict) and the branch resolution / commit path (update).

Parameters:
IDX_W, 8, table index width; depth = 2^IDX_W entries
CTR_W, 2, saturating counter width (>=1)
INIT_VAL, (1<<(CTR_W-1))-1, counter value written by init sweep (weakly not-taken)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pulse; restarts init sweep
init_busy  output  1  high while init sweep runs
pred_valid  input  1  predict request
pred_idx  input  IDX_W  predict index
pred_resp_valid  output  1  predict response valid, one cycle after acceptance
pred_ctr  output  CTR_W  counter value of requested entry
pred_taken  output  1  MSB of pred_ctr
upd_valid  input  1  update request
upd_idx  input  IDX_W  update index
upd_taken  input  1  resolved direction
upd_ready  output  1  update accepted when upd_valid & upd_ready

Behaviour:
- Storage is a flip-flop array, mem[0 .. 2^IDX_W-1] of CTR_W bits.
- FSM states: INIT and READY.
  - Async reset puts the FSM in INIT with init_cnt=0. Outputs during reset: init_busy=1, pred_resp_valid=0, pred_ctr=0, upd_ready=0.
  - In INIT, each cycle writes mem[init_cnt]=INIT_VAL and increments init_cnt.
  - When init_cnt reaches 2^IDX_W-1, that entry is written and the FSM moves to READY. The sweep takes exactly 2^IDX_W cycles.
  - In INIT: init_busy=1 and upd_ready=0. pred_valid is ignored, so pred_resp_valid stays 0. upd_valid is dropped.
  - flush in any state forces INIT with init_cnt=0 at the next edge. Any registered pending update is discarded and pred_resp_valid is cleared. flush during INIT restarts the sweep from 0.
  - Reset asserted mid-sweep or mid-update aborts it. No partial state matters because the sweep reruns.
- Predict path (READY only):
  - A request is accepted at edge E when pred_valid=1.
  - At E: pred_resp_valid<=1 and pred_ctr<=entry value.
  - If the update being written at edge E targets the same index, the newly written value is forwarded.
  - The response therefore reflects all updates accepted before E, but not one accepted at E.
  - pred_resp_valid<=0 when no request is accepted. pred_ctr holds its last value.
- Update path (READY only):
  - upd_ready=1 in READY. An update accepted at edge E is registered as idx and taken.
  - At edge E+1, mem[idx] is replaced by the saturated result:
    - taken: ctr+1, saturating at 2^CTR_W-1.
    - not-taken: ctr-1, saturating at 0.
  - Updates may be accepted every cycle. Back-to-back updates to the same index accumulate correctly, because the later update reads mem after the earlier write edge.
  - Update and predict on the same index in the same cycle is legal. Ordering is as defined under the predict path.
- Arithmetic is unsigned CTR_W-bit. No wrap-around is permitted at either end.
- pred_taken = pred_ctr[CTR_W-1].

Test Plan:
- Reset, then idle -> init_busy=1 for exactly 256 cycles, then 0. Predicting every index gives pred_ctr=1 and pred_taken=0 for all.
- Update idx 0x3C taken 4 times back-to-back, then predict 0x3C -> pred_ctr=3 (saturated). Then 5 not-taken updates, then predict -> pred_ctr=0.
- Update idx 0x10 taken accepted at E, predict 0x10 accepted at E+1 -> response 2 (forwarded). Predict accepted at E itself -> response 1.
- flush asserted after entries were modified, with an update in flight -> init_busy rises. The in-flight update is not applied. After 256 cycles every entry reads 1.
- Assert rst_n low mid-sweep at cnt=100 and during pred_valid in INIT -> no pred_resp_valid. The sweep restarts at 0 and completes in 256 cycles after release.
- CTR_W=3, IDX_W=4 instance -> INIT_VAL=3 and a 16-cycle sweep. Saturation is at 7 and 0.

Source files
------------

// File: rtl/gshare_pht.sv
// Pattern history table for the gshare predictor: 2^IDX_W saturating counters with
// an independent predict port and an internal read-modify-write update port.
module gshare_pht #(
    parameter int              IDX_W    = 8,
    parameter int              CTR_W    = 2,
    parameter logic [CTR_W-1:0] INIT_VAL = CTR_W'((1 << (CTR_W - 1)) - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             init_busy,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_resp_valid,
    output logic [CTR_W-1:0] pred_ctr,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready
);

    localparam int DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_init_cnt;
    logic [CTR_W-1:0] r_mem [DEPTH];

    logic             r_upd_vld;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_upd_taken;

    logic             r_pred_resp_valid;
    logic [CTR_W-1:0] r_pred_ctr;

    logic             w_ready;
    logic             w_upd_fire;
    logic [CTR_W-1:0] w_upd_new;
    logic [CTR_W-1:0] w_pred_rd;

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr, input logic up);
        if (up)
            return (&ctr) ? ctr : ctr + CTR_W'(1);
        else
            return (ctr == '0) ? ctr : ctr - CTR_W'(1);
    endfunction

    assign w_ready    = (r_state == ST_READY);
    assign w_upd_fire = upd_valid & w_ready;
    assign w_upd_new  = sat_step(r_mem[r_upd_idx], r_upd_taken);

    // A predict that coincides with the write of the same entry sees the new value
    assign w_pred_rd = (r_upd_vld && (r_upd_idx == pred_idx)) ? w_upd_new : r_mem[pred_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_INIT;
            r_init_cnt        <= '0;
            r_upd_vld         <= 1'b0;
            r_pred_resp_valid <= 1'b0;
            r_pred_ctr        <= '0;
        end else if (flush) begin
            r_state           <= ST_INIT;
            r_init_cnt        <= '0;
            r_upd_vld         <= 1'b0;
            r_pred_resp_valid <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt        <= r_init_cnt + IDX_W'(1);
            r_upd_vld         <= 1'b0;
            r_pred_resp_valid <= 1'b0;
            if (&r_init_cnt)
                r_state <= ST_READY;
        end else begin
            r_upd_vld         <= upd_valid;
            r_pred_resp_valid <= pred_valid;
            if (pred_valid)
                r_pred_ctr <= w_pred_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (w_upd_fire) begin
            r_upd_idx   <= upd_idx;
            r_upd_taken <= upd_taken;
        end
    end

    // Flush discards the pending update; the sweep starts on the following edge
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (r_state == ST_INIT)
                r_mem[r_init_cnt] <= INIT_VAL;
            else if (r_upd_vld)
                r_mem[r_upd_idx] <= w_upd_new;
        end
    end

    assign init_busy       = (r_state == ST_INIT);
    assign upd_ready       = w_ready;
    assign pred_resp_valid = r_pred_resp_valid;
    assign pred_ctr        = r_pred_ctr;
    assign pred_taken      = r_pred_ctr[CTR_W-1];

endmodule

// File: tb/tb_gshare_pht.sv
// Randomized and directed bench for gshare_pht against a sequential reference model,
// plus a small IDX_W=4 / CTR_W=3 instance for width and saturation corners.
module tb_gshare_pht;

    localparam int DEPTH = 256;
    localparam int CMAX  = 3;
    localparam int INITV = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       init_busy;
    logic       pred_valid;
    logic [7:0] pred_idx;
    logic       pred_resp_valid;
    logic [1:0] pred_ctr;
    logic       pred_taken;
    logic       upd_valid;
    logic [7:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;

    logic       s_rst_n;
    logic       s_flush;
    logic       s_init_busy;
    logic       s_pred_valid;
    logic [3:0] s_pred_idx;
    logic       s_pred_resp_valid;
    logic [2:0] s_pred_ctr;
    logic       s_pred_taken;
    logic       s_upd_valid;
    logic [3:0] s_upd_idx;
    logic       s_upd_taken;
    logic       s_upd_ready;

    gshare_pht u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .init_busy      (init_busy),
        .pred_valid     (pred_valid),
        .pred_idx       (pred_idx),
        .pred_resp_valid(pred_resp_valid),
        .pred_ctr       (pred_ctr),
        .pred_taken     (pred_taken),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_ready      (upd_ready)
    );

    gshare_pht #(.IDX_W(4), .CTR_W(3)) u_small (
        .clk            (clk),
        .rst_n          (s_rst_n),
        .flush          (s_flush),
        .init_busy      (s_init_busy),
        .pred_valid     (s_pred_valid),
        .pred_idx       (s_pred_idx),
        .pred_resp_valid(s_pred_resp_valid),
        .pred_ctr       (s_pred_ctr),
        .pred_taken     (s_pred_taken),
        .upd_valid      (s_upd_valid),
        .upd_idx        (s_upd_idx),
        .upd_taken      (s_upd_taken),
        .upd_ready      (s_upd_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model: table contents plus at most one accepted-but-unapplied update
    int m_mem [DEPTH];
    bit m_ready;
    int m_cnt;
    bit m_pv;
    int m_pidx;
    bit m_pt;
    int exp_rv;
    int exp_ctr;

    function automatic int sat(input int c, input bit up, input int cmax);
        int n;
        n = up ? c + 1 : c - 1;
        if (n > cmax) n = cmax;
        if (n < 0) n = 0;
        return n;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_cnt   = 0;
        m_pv    = 1'b0;
        exp_rv  = 0;
        exp_ctr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (flush) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_pv    = 1'b0;
            exp_rv  = 0;
        end else if (!m_ready) begin
            m_mem[m_cnt] = INITV;
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b1;
            exp_rv = 0;
        end else begin
            if (m_pv) m_mem[m_pidx] = sat(m_mem[m_pidx], m_pt, CMAX);
            exp_rv = pred_valid;
            if (pred_valid) exp_ctr = m_mem[int'(pred_idx)];
            m_pv   = upd_valid;
            m_pidx = int'(upd_idx);
            m_pt   = upd_taken;
        end
        #1;
        chk("init_busy", int'(init_busy), int'(!m_ready));
        chk("upd_ready", int'(upd_ready), int'(m_ready));
        chk("pred_resp_valid", int'(pred_resp_valid), exp_rv);
        chk("pred_ctr", int'(pred_ctr), exp_ctr);
        chk("pred_taken", int'(pred_taken), exp_ctr >> 1);
    endtask

    task automatic cyc(input bit pv, input int pidx, input bit uv, input int uidx, input bit ut);
        flush      = 1'b0;
        pred_valid = pv;
        pred_idx   = pidx[7:0];
        upd_valid  = uv;
        upd_idx    = uidx[7:0];
        upd_taken  = ut;
        step();
    endtask

    task automatic idle();
        flush      = 1'b0;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 2000) begin
            step();
            n++;
        end
        chk(tag, n, 256);
    endtask

    task automatic predict_all();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, i, 1'b0, 0, 1'b0);
        idle();
    endtask

    task automatic s_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int n;
        int idx;

        rst_n = 1'b0;
        s_rst_n = 1'b0;
        s_flush = 1'b0;
        s_pred_valid = 1'b0;
        s_pred_idx = '0;
        s_upd_valid = 1'b0;
        s_upd_idx = '0;
        s_upd_taken = 1'b0;
        pred_idx = '0;
        upd_idx = '0;
        upd_taken = 1'b0;
        idle();
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

        #2;
        chk("rst_init_busy", int'(init_busy), 1);
        chk("rst_resp_valid", int'(pred_resp_valid), 0);
        chk("rst_pred_ctr", int'(pred_ctr), 0);
        chk("rst_upd_ready", int'(upd_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_sweep("sweep_after_reset");
        predict_all();

        // Saturation at the top and bottom of entry 0x3C
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 'h3C, 1'b1);
        cyc(1'b1, 'h3C, 1'b0, 0, 1'b0);
        chk("sat_hi_3c", int'(pred_ctr), 3);
        for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b1, 'h3C, 1'b0);
        cyc(1'b1, 'h3C, 1'b0, 0, 1'b0);
        chk("sat_lo_3c", int'(pred_ctr), 0);
        chk("sat_lo_3c_taken", int'(pred_taken), 0);

        // Same-cycle predict sees the old value; the next one sees the forwarded write
        cyc(1'b1, 'h10, 1'b1, 'h10, 1'b1);
        chk("same_edge_0x10", int'(pred_ctr), 1);
        cyc(1'b1, 'h10, 1'b0, 0, 1'b0);
        chk("fwd_0x10", int'(pred_ctr), 2);
        chk("fwd_0x10_taken", int'(pred_taken), 1);

        // Random traffic concentrated on a few entries, with rare flushes
        for (int k = 0; k < 3000; k++) begin
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range('h40, 'h47));
            pred_idx = idx[7:0];
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range('h40, 'h47));
            upd_idx    = idx[7:0];
            pred_valid = 1'($urandom_range(0, 1));
            upd_valid  = 1'($urandom_range(0, 1));
            upd_taken  = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 999) == 0);
            step();
        end
        idle();
        if (init_busy === 1'b1) wait_sweep("sweep_after_rand_flush");

        // Flush with an update in flight discards it and re-initialises every entry
        cyc(1'b0, 0, 1'b1, 'h20, 1'b1);
        cyc(1'b0, 0, 1'b1, 'h21, 1'b1);
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", int'(init_busy), 1);
        wait_sweep("sweep_after_flush");
        cyc(1'b1, 'h21, 1'b0, 0, 1'b0);
        chk("flush_0x21", int'(pred_ctr), 1);
        predict_all();

        // Reset mid-sweep while predicts are requested
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) cyc(1'b1, i, 1'b1, i, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", int'(init_busy), 1);
        chk("midrst_resp_valid", int'(pred_resp_valid), 0);
        chk("midrst_pred_ctr", int'(pred_ctr), 0);
        @(posedge clk);
        #1;
        chk("midrst_held_resp", int'(pred_resp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep("sweep_after_midrst");
        idle();
        predict_all();

        // Small instance: 16-entry sweep, INIT_VAL 3, saturation at 7 and 0
        @(negedge clk);
        s_rst_n = 1'b1;
        n = 0;
        while (s_init_busy === 1'b1 && n < 200) begin
            s_step();
            n++;
        end
        chk("s_sweep_len", n, 16);
        chk("s_upd_ready", int'(s_upd_ready), 1);
        s_pred_valid = 1'b1;
        s_pred_idx = 4'd9;
        s_step();
        s_pred_valid = 1'b0;
        chk("s_init_val", int'(s_pred_ctr), 3);
        chk("s_init_resp", int'(s_pred_resp_valid), 1);
        e = 3;
        for (int i = 0; i < 6; i++) begin
            s_upd_valid = 1'b1;
            s_upd_idx = 4'd5;
            s_upd_taken = 1'b1;
            s_step();
            e = sat(e, 1'b1, 7);
        end
        s_upd_valid = 1'b0;
        s_pred_valid = 1'b1;
        s_pred_idx = 4'd5;
        s_step();
        s_pred_valid = 1'b0;
        chk("s_sat_hi", int'(s_pred_ctr), e);
        chk("s_sat_hi_taken", int'(s_pred_taken), 1);
        for (int i = 0; i < 9; i++) begin
            s_upd_valid = 1'b1;
            s_upd_idx = 4'd5;
            s_upd_taken = 1'b0;
            s_step();
            e = sat(e, 1'b0, 7);
        end
        s_upd_valid = 1'b0;
        s_pred_valid = 1'b1;
        s_step();
        s_pred_valid = 1'b0;
        chk("s_sat_lo", int'(s_pred_ctr), e);
        chk("s_sat_lo_taken", int'(s_pred_taken), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
